mips_alu_reg: RTL and testbench
===============================

Name: mips_alu_reg

Overview:
- 32-bit MIPS-style execute-stage ALU.
- Decodes OPCODE/FUNC and computes a result from RS_VAL, RT_VAL, SHAMT or the 16-bit immediate RAW_VAL.
- Raises a branch-taken flag SIG_B for conditional branches.
- Outputs are registered (one-cycle latency) and feed the memory/writeback stage and the branch logic.

Parameters:
- None. All widths are fixed: 32-bit data, 6-bit OPCODE/FUNC, 5-bit SHAMT, 16-bit immediate.

Ports:
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous active-low reset
- OPCODE  input  6  instruction opcode field
- RS_VAL  input  32  rs register operand
- RT_VAL  input  32  rt register operand
- SHAMT  input  5  shift amount field
- FUNC  input  6  R-type function field
- RAW_VAL  input  16  raw immediate field
- RESULT  output  32  registered ALU result
- SIG_B  output  1  registered branch-taken flag

Behaviour:
- Reset and latency:
  - RST_N low forces RESULT=0 and SIG_B=0 immediately, independent of CLK, and holds them while low.
  - After reset release, each rising CLK registers the combinational result of the current inputs. Latency is exactly 1 cycle, and a new operation is accepted every cycle.
- Immediate extension:
  - SEXT = {16{RAW_VAL[15]}, RAW_VAL}
  - ZEXT = {16'b0, RAW_VAL}
- Arithmetic: all add/sub wrap modulo 2^32. There is no overflow trap or flag; ADD/ADDU and SUB/SUBU give identical results.
- R-type (OPCODE=000000), selected by FUNC:
  - 000000 SLL: RT<<SHAMT
  - 000010 SRL: RT>>SHAMT, logical (zero fill)
  - 000011 SRA: RT>>>SHAMT, arithmetic
  - 000100 SLLV / 000110 SRLV / 000111 SRAV: as above, shift amount RS_VAL[4:0]
  - 100000/100001 ADD/ADDU: RS+RT
  - 100010/100011 SUB/SUBU: RS-RT
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR (~(RS|RT))
  - 101010 SLT: signed RS<RT gives 1, else 0
  - 101011 SLTU: same comparison, unsigned
  - Any other FUNC: RESULT=0
  - SIG_B=0 for all R-type.
- I-type:
  - 001000 ADDI / 001001 ADDIU: RS+SEXT
  - 001010 SLTI: signed RS<SEXT
  - 001011 SLTIU: unsigned RS<SEXT
  - 001100 ANDI: RS&ZEXT
  - 001101 ORI: RS|ZEXT
  - 001110 XORI: RS^ZEXT
  - 001111 LUI: {RAW_VAL,16'b0}
  - 100011 LW / 101011 SW: effective address RS+SEXT
- Branches: RESULT = SEXT<<2 (byte offset).
  - 000100 BEQ: SIG_B = (RS==RT)
  - 000101 BNE: SIG_B = (RS!=RT)
  - 000110 BLEZ: SIG_B = signed RS<=0
  - 000111 BGTZ: SIG_B = signed RS>0
- Unlisted opcodes: RESULT=0, SIG_B=0.
- Boundaries:
  - SHAMT=0 passes RT unchanged.
  - SRA of a negative value fills with ones.
  - Shift amount 31 is valid.
  - 0x7FFFFFFF+1 = 0x80000000 with no trap.
  - Reset asserted mid-stream discards the in-flight result.
  - RT_VAL is ignored by I-type non-branch operations.

Test Plan:
- Reset, then SRL (OPCODE=0, FUNC=000010, SHAMT=1) with RT=12, 22, 35 (RS=15, 23, 1) -> RESULT 6, 11, 17 one cycle after each apply; SIG_B=0.
- SRA with RT=0x80000010, SHAMT=4 -> 0xF8000001. SLLV with RT=1, RS=31 -> 0x80000000.
- ADD 0x7FFFFFFF+1 -> 0x80000000. SUB 3-5 -> 0xFFFFFFFE. SLT RS=-1, RT=1 -> 1. SLTU with the same operands -> 0.
- ADDI RS=10, RAW=0xFFFF -> 9. ORI RS=0, RAW=0x8001 -> 0x00008001. LUI RAW=0x1234 -> 0x12340000.
- BEQ RS=RT=5, RAW=3 -> SIG_B=1, RESULT=12. BNE with the same operands -> SIG_B=0. BLEZ RS=0 -> 1. BGTZ RS=0x80000000 -> 0.
- Assert RST_N low between clock edges while RESULT is non-zero -> RESULT=0 and SIG_B=0 immediately. On release, the next edge loads the current operation.

Source files
------------

// File: rtl/mips_alu_reg.sv
// mips_alu_reg: 32-bit MIPS-style execute-stage ALU with registered result
// and branch-taken flag. Each cycle accepts a new operation; latency is one
// cycle. Arithmetic wraps modulo 2^32 and never traps.
module mips_alu_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [4:0]  shamt,
  input  logic [5:0]  func,
  input  logic [15:0] raw_val,
  output logic [31:0] result,
  output logic        sig_b
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned SH_W   = 5;

  // Opcode encodings
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function encodings
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // Immediate extensions and derived operands
  logic [DATA_W-1:0] sext_c;
  logic [DATA_W-1:0] zext_c;
  logic [DATA_W-1:0] br_off_c;
  logic [SH_W-1:0]   var_sh_c;
  logic [DATA_W-1:0] add_rt_c;
  logic [DATA_W-1:0] add_imm_c;
  logic [DATA_W-1:0] sub_rt_c;
  logic              slt_rt_c;
  logic              sltu_rt_c;
  logic              slt_imm_c;
  logic              sltu_imm_c;
  logic              rs_zero_c;
  logic              rs_neg_c;

  // Shared operand preparation: extensions, adders and comparators
  always_comb begin
    sext_c     = {{(DATA_W-IMM_W){raw_val[IMM_W-1]}}, raw_val};
    zext_c     = {{(DATA_W-IMM_W){1'b0}}, raw_val};
    br_off_c   = {sext_c[DATA_W-3:0], 2'b00};
    var_sh_c   = rs_val[SH_W-1:0];
    add_rt_c   = rs_val + rt_val;
    add_imm_c  = rs_val + sext_c;
    sub_rt_c   = rs_val - rt_val;
    slt_rt_c   = $signed(rs_val) < $signed(rt_val);
    sltu_rt_c  = rs_val < rt_val;
    slt_imm_c  = $signed(rs_val) < $signed(sext_c);
    sltu_imm_c = rs_val < sext_c;
    rs_zero_c  = (rs_val == '0);
    rs_neg_c   = rs_val[DATA_W-1];
  end

  // Barrel shifts for both fixed and register-specified amounts
  logic [DATA_W-1:0] sll_c;
  logic [DATA_W-1:0] srl_c;
  logic [DATA_W-1:0] sra_c;
  logic [DATA_W-1:0] sllv_c;
  logic [DATA_W-1:0] srlv_c;
  logic [DATA_W-1:0] srav_c;

  // Shift datapath
  always_comb begin
    sll_c  = rt_val << shamt;
    srl_c  = rt_val >> shamt;
    sra_c  = DATA_W'($signed(rt_val) >>> shamt);
    sllv_c = rt_val << var_sh_c;
    srlv_c = rt_val >> var_sh_c;
    srav_c = DATA_W'($signed(rt_val) >>> var_sh_c);
  end

  // R-type result selection by function field
  logic [DATA_W-1:0] rtype_c;

  always_comb begin
    rtype_c = '0;
    unique case (func)
      FN_SLL:          rtype_c = sll_c;
      FN_SRL:          rtype_c = srl_c;
      FN_SRA:          rtype_c = sra_c;
      FN_SLLV:         rtype_c = sllv_c;
      FN_SRLV:         rtype_c = srlv_c;
      FN_SRAV:         rtype_c = srav_c;
      FN_ADD, FN_ADDU: rtype_c = add_rt_c;
      FN_SUB, FN_SUBU: rtype_c = sub_rt_c;
      FN_AND:          rtype_c = rs_val & rt_val;
      FN_OR:           rtype_c = rs_val | rt_val;
      FN_XOR:          rtype_c = rs_val ^ rt_val;
      FN_NOR:          rtype_c = ~(rs_val | rt_val);
      FN_SLT:          rtype_c = DATA_W'(slt_rt_c);
      FN_SLTU:         rtype_c = DATA_W'(sltu_rt_c);
      default:         rtype_c = '0;
    endcase
  end

  // Top-level decode: next result and branch-taken flag
  logic [DATA_W-1:0] result_c;
  logic              sig_b_c;

  always_comb begin
    result_c = '0;
    sig_b_c  = 1'b0;
    unique case (opcode)
      OP_RTYPE:          result_c = rtype_c;
      OP_ADDI, OP_ADDIU: result_c = add_imm_c;
      OP_SLTI:           result_c = DATA_W'(slt_imm_c);
      OP_SLTIU:          result_c = DATA_W'(sltu_imm_c);
      OP_ANDI:           result_c = rs_val & zext_c;
      OP_ORI:            result_c = rs_val | zext_c;
      OP_XORI:           result_c = rs_val ^ zext_c;
      OP_LUI:            result_c = {raw_val, {IMM_W{1'b0}}};
      OP_LW, OP_SW:      result_c = add_imm_c;
      OP_BEQ: begin
        result_c = br_off_c;
        sig_b_c  = (rs_val == rt_val);
      end
      OP_BNE: begin
        result_c = br_off_c;
        sig_b_c  = (rs_val != rt_val);
      end
      OP_BLEZ: begin
        result_c = br_off_c;
        sig_b_c  = rs_neg_c | rs_zero_c;
      end
      OP_BGTZ: begin
        result_c = br_off_c;
        sig_b_c  = ~rs_neg_c & ~rs_zero_c;
      end
      default: begin
        result_c = '0;
        sig_b_c  = 1'b0;
      end
    endcase
  end

  // Output register; reset discards any in-flight result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      sig_b  <= 1'b0;
    end else begin
      result <= result_c;
      sig_b  <= sig_b_c;
    end
  end

endmodule

// File: tb/tb_mips_alu_reg.sv
// tb_mips_alu_reg: directed vectors with hand-computed expectations for
// mips_alu_reg, including reset behaviour and shift/arith boundaries.
module tb_mips_alu_reg;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [4:0]  shamt;
  logic [5:0]  func;
  logic [15:0] raw_val;
  logic [31:0] result;
  logic        sig_b;

  int checks = 0;
  int errors = 0;

  mips_alu_reg dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .opcode  (opcode),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .shamt   (shamt),
    .func    (func),
    .raw_val (raw_val),
    .result  (result),
    .sig_b   (sig_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Drive one operation on the falling edge, then sample just after the rising edge
  task automatic apply(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] raw);
    @(negedge clk);
    opcode  = op;
    func    = fn;
    shamt   = sh;
    rs_val  = rs;
    rt_val  = rt;
    raw_val = raw;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    opcode  = 6'h3f;
    func    = 6'h00;
    shamt   = 5'd0;
    rs_val  = 32'h0;
    rt_val  = 32'h0;
    raw_val = 16'h0;
    #2;
    chk32("reset_result", result, 32'h0);
    chk1 ("reset_sig_b", sig_b, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // SRL by 1 across three operands
    apply(6'h00, 6'b000010, 5'd1, 32'd15, 32'd12, 16'h0);
    chk32("srl_12", result, 32'd6);  chk1("srl_12_b", sig_b, 1'b0);
    apply(6'h00, 6'b000010, 5'd1, 32'd23, 32'd22, 16'h0);
    chk32("srl_22", result, 32'd11); chk1("srl_22_b", sig_b, 1'b0);
    apply(6'h00, 6'b000010, 5'd1, 32'd1, 32'd35, 16'h0);
    chk32("srl_35", result, 32'd17); chk1("srl_35_b", sig_b, 1'b0);

    // Shift boundaries
    apply(6'h00, 6'b000010, 5'd0, 32'h0, 32'hDEADBEEF, 16'h0);
    chk32("srl_sh0", result, 32'hDEADBEEF);
    apply(6'h00, 6'b000011, 5'd4, 32'h0, 32'h80000010, 16'h0);
    chk32("sra_neg", result, 32'hF8000001);
    apply(6'h00, 6'b000011, 5'd31, 32'h0, 32'h80000000, 16'h0);
    chk32("sra_31", result, 32'hFFFFFFFF);
    apply(6'h00, 6'b000100, 5'd0, 32'd31, 32'd1, 16'h0);
    chk32("sllv_31", result, 32'h80000000);
    apply(6'h00, 6'b000111, 5'd0, 32'd36, 32'h80000010, 16'h0);
    chk32("srav_lo5", result, 32'hF8000001);

    // Arithmetic and logic
    apply(6'h00, 6'b100000, 5'd0, 32'h7FFFFFFF, 32'd1, 16'h0);
    chk32("add_wrap", result, 32'h80000000);
    apply(6'h00, 6'b100010, 5'd0, 32'd3, 32'd5, 16'h0);
    chk32("sub_neg", result, 32'hFFFFFFFE);
    apply(6'h00, 6'b101010, 5'd0, 32'hFFFFFFFF, 32'd1, 16'h0);
    chk32("slt", result, 32'd1);
    apply(6'h00, 6'b101011, 5'd0, 32'hFFFFFFFF, 32'd1, 16'h0);
    chk32("sltu", result, 32'd0);
    apply(6'h00, 6'b100111, 5'd0, 32'h00FF0000, 32'h0000FF00, 16'h0);
    chk32("nor", result, 32'hFF0000FF);
    apply(6'h00, 6'b000001, 5'd3, 32'h12345678, 32'h9ABCDEF0, 16'h0);
    chk32("rtype_bad_func", result, 32'h0);

    // I-type
    apply(6'b001000, 6'h00, 5'd0, 32'd10, 32'h0, 16'hFFFF);
    chk32("addi", result, 32'd9);
    apply(6'b001101, 6'h00, 5'd0, 32'h0, 32'h0, 16'h8001);
    chk32("ori", result, 32'h00008001);
    apply(6'b001111, 6'h00, 5'd0, 32'h0, 32'h0, 16'h1234);
    chk32("lui", result, 32'h12340000);
    apply(6'b001110, 6'h00, 5'd0, 32'hFFFF0000, 32'h12345678, 16'h00FF);
    chk32("xori_rt_ignored", result, 32'hFFFF00FF);
    apply(6'b001011, 6'h00, 5'd0, 32'd5, 32'h0, 16'hFFFF);
    chk32("sltiu_sext", result, 32'd1);
    apply(6'b100011, 6'h00, 5'd0, 32'h00001000, 32'hFFFFFFFF, 16'hFFFC);
    chk32("lw_addr", result, 32'h00000FFC);

    // Branches
    apply(6'b000100, 6'h00, 5'd0, 32'd5, 32'd5, 16'd3);
    chk32("beq_off", result, 32'd12); chk1("beq_b", sig_b, 1'b1);
    apply(6'b000101, 6'h00, 5'd0, 32'd5, 32'd5, 16'd3);
    chk32("bne_off", result, 32'd12); chk1("bne_b", sig_b, 1'b0);
    apply(6'b000100, 6'h00, 5'd0, 32'd5, 32'd6, 16'hFFFF);
    chk32("beq_negoff", result, 32'hFFFFFFFC); chk1("beq_nt_b", sig_b, 1'b0);
    apply(6'b000110, 6'h00, 5'd0, 32'h0, 32'h0, 16'h0);
    chk1("blez_zero", sig_b, 1'b1);
    apply(6'b000111, 6'h00, 5'd0, 32'h80000000, 32'h0, 16'h0);
    chk1("bgtz_neg", sig_b, 1'b0);
    apply(6'b000111, 6'h00, 5'd0, 32'd7, 32'h0, 16'h1);
    chk1("bgtz_pos", sig_b, 1'b1); chk32("bgtz_off", result, 32'd4);

    // Unlisted opcode
    apply(6'b111111, 6'h00, 5'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'hFFFF);
    chk32("bad_op", result, 32'h0); chk1("bad_op_b", sig_b, 1'b0);

    // Asynchronous reset mid-stream
    apply(6'b000100, 6'h00, 5'd0, 32'd9, 32'd9, 16'h0100);
    chk32("pre_rst", result, 32'h00000400); chk1("pre_rst_b", sig_b, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk32("async_rst", result, 32'h0); chk1("async_rst_b", sig_b, 1'b0);
    @(posedge clk);
    #1;
    chk32("rst_hold", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk32("post_rst", result, 32'h00000400); chk1("post_rst_b", sig_b, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
